// File: rtl/ahb_req_arbiter.sv
// ahb_req_arbiter: round-robin arbiter that shares the single ahbmaster_wrapper
// request port among NUM_REQ EFLX-side requesters. The winner's address,
// direction and clamped burst length are latched. Beats are counted, a
// no-progress watchdog aborts stalled transfers, and per-requester done/err
// pulses are produced.

module ahb_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 5,
    parameter int TIMEOUT    = 64
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_wack,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]            req_rvalid,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [NUM_REQ-1:0]            req_err,
    output logic [NUM_REQ-1:0]            grant,
    output logic [ADDR_WIDTH-1:0]         TARGET_ADDRESS,
    output logic                          writereq,
    output logic                          readreq,
    output logic [DATA_WIDTH-1:0]         eflx_rdata,
    input  logic                          eflx_rvalid_data,
    input  logic                          eflx_wvalid_data,
    input  logic [DATA_WIDTH-1:0]         eflx_wdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CNT_W = 5;
    localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]     NUM_REQ_C = (IDX_W + 1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Burst length as used by the beat counter: 0 means one beat, anything
    // above 16 is limited to a 16-beat burst.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [LEN_WIDTH-1:0] raw);
        logic [31:0] ext;
        ext = 32'(raw);
        if (ext == 32'd0) begin
            clamp_len = 5'd1;
        end else if (ext > 32'd16) begin
            clamp_len = 5'd16;
        end else begin
            clamp_len = ext[CNT_W-1:0];
        end
    endfunction

    state_t                  state_r, state_n;
    logic [NUM_REQ-1:0]      grant_r, grant_n;
    logic [IDX_W-1:0]        gidx_r, gidx_n;
    logic [IDX_W-1:0]        ptr_r, ptr_n;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_n;
    logic                    writereq_r, writereq_n;
    logic                    readreq_r, readreq_n;
    logic [NUM_REQ-1:0]      done_r, done_n;
    logic [NUM_REQ-1:0]      err_r, err_n;
    logic [CNT_W-1:0]        len_r, len_n;
    logic [CNT_W-1:0]        beat_r, beat_n;
    logic [WD_W-1:0]         wdog_r, wdog_n;

    logic                    win_found_s;
    logic [IDX_W-1:0]        win_idx_s;
    logic [IDX_W:0]          cand_s;
    logic                    ack_s;
    logic [DATA_WIDTH-1:0]   eflx_rdata_s;

    // Round-robin search: nearest asserted request after the last owner, with wrap.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s = {1'b0, ptr_r} + (IDX_W + 1)'(k);
            if (cand_s >= NUM_REQ_C) begin
                cand_s = cand_s - NUM_REQ_C;
            end else begin
                cand_s = cand_s;
            end
            if (req_valid[cand_s[IDX_W-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[IDX_W-1:0];
            end else begin
                win_found_s = win_found_s;
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Beat acknowledge follows the direction of the running transfer only.
    always_comb begin
        ack_s = 1'b0;
        if (writereq_r) begin
            ack_s = eflx_rvalid_data;
        end else if (readreq_r) begin
            ack_s = eflx_wvalid_data;
        end else begin
            ack_s = 1'b0;
        end
    end

    // Next-state and next-register values of the arbitration FSM.
    always_comb begin
        state_n    = state_r;
        grant_n    = grant_r;
        gidx_n     = gidx_r;
        ptr_n      = ptr_r;
        addr_n     = addr_r;
        writereq_n = writereq_r;
        readreq_n  = readreq_r;
        done_n     = '0;
        err_n      = '0;
        len_n      = len_r;
        beat_n     = beat_r;
        wdog_n     = wdog_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    grant_n    = ONE_HOT0 << win_idx_s;
                    gidx_n     = win_idx_s;
                    addr_n     = req_addr[int'(win_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
                    writereq_n = req_write[win_idx_s];
                    readreq_n  = ~req_write[win_idx_s];
                    len_n      = clamp_len(req_len[int'(win_idx_s)*LEN_WIDTH +: LEN_WIDTH]);
                    beat_n     = '0;
                    wdog_n     = '0;
                    state_n    = ST_XFER;
                end else begin
                    state_n    = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (ack_s) begin
                    wdog_n = '0;
                    if (beat_r == (len_r - 5'd1)) begin
                        writereq_n = 1'b0;
                        readreq_n  = 1'b0;
                        done_n     = grant_r;
                        state_n    = ST_DONE;
                    end else begin
                        beat_n     = beat_r + 5'd1;
                    end
                end else if (wdog_r == WD_LAST) begin
                    writereq_n = 1'b0;
                    readreq_n  = 1'b0;
                    err_n      = grant_r;
                    state_n    = ST_DONE;
                end else begin
                    wdog_n     = wdog_r + WD_W'(1);
                end
            end
            ST_DONE: begin
                ptr_n   = gidx_r;
                grant_n = '0;
                state_n = ST_IDLE;
            end
            default: begin
                grant_n    = '0;
                writereq_n = 1'b0;
                readreq_n  = 1'b0;
                state_n    = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset leaves requester 0 with first priority.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            gidx_r     <= '0;
            ptr_r      <= IDX_W'(NUM_REQ - 1);
            addr_r     <= '0;
            writereq_r <= 1'b0;
            readreq_r  <= 1'b0;
            done_r     <= '0;
            err_r      <= '0;
            len_r      <= '0;
            beat_r     <= '0;
            wdog_r     <= '0;
        end else begin
            state_r    <= state_n;
            grant_r    <= grant_n;
            gidx_r     <= gidx_n;
            ptr_r      <= ptr_n;
            addr_r     <= addr_n;
            writereq_r <= writereq_n;
            readreq_r  <= readreq_n;
            done_r     <= done_n;
            err_r      <= err_n;
            len_r      <= len_n;
            beat_r     <= beat_n;
            wdog_r     <= wdog_n;
        end
    end

    // Write-data steering from the current owner; zero when nobody is granted.
    always_comb begin
        eflx_rdata_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_r[i]) begin
                eflx_rdata_s = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                eflx_rdata_s = eflx_rdata_s;
            end
        end
    end

    assign req_wack       = {NUM_REQ{eflx_rvalid_data & writereq_r}} & grant_r;
    assign req_rvalid     = {NUM_REQ{eflx_wvalid_data & readreq_r}} & grant_r;
    assign req_rdata      = eflx_wdata;
    assign req_done       = done_r;
    assign req_err        = err_r;
    assign grant          = grant_r;
    assign TARGET_ADDRESS = addr_r;
    assign writereq       = writereq_r;
    assign readreq        = readreq_r;
    assign eflx_rdata     = eflx_rdata_s;

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Randomized self-checking bench for ahb_req_arbiter against a transfer-level
// reference model (owner, beats remaining, silent-cycle count).

module tb_ahb_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 5;
    localparam int TO = 64;
    localparam int NCYC = 4000;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*LW-1:0]  req_len;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_wack;
    logic [DW-1:0]     req_rdata;
    logic [NR-1:0]     req_rvalid;
    logic [NR-1:0]     req_done;
    logic [NR-1:0]     req_err;
    logic [NR-1:0]     grant;
    logic [AW-1:0]     TARGET_ADDRESS;
    logic              writereq;
    logic              readreq;
    logic [DW-1:0]     eflx_rdata;
    logic              eflx_rvalid_data;
    logic              eflx_wvalid_data;
    logic [DW-1:0]     eflx_wdata;

    ahb_req_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(TO)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata), .req_wack(req_wack),
        .req_rdata(req_rdata), .req_rvalid(req_rvalid), .req_done(req_done),
        .req_err(req_err), .grant(grant), .TARGET_ADDRESS(TARGET_ADDRESS),
        .writereq(writereq), .readreq(readreq), .eflx_rdata(eflx_rdata),
        .eflx_rvalid_data(eflx_rvalid_data), .eflx_wvalid_data(eflx_wvalid_data),
        .eflx_wdata(eflx_wdata)
    );

    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: -1 means "no requester".
    int             m_owner;
    int             m_last;
    int             m_left;
    int             m_silent;
    bit             m_active;
    bit             m_wr;
    logic [AW-1:0]  m_addr;
    int             m_done;
    int             m_err;
    int             m_done_cnt = 0;
    int             m_err_cnt  = 0;
    int             d_done_cnt = 0;
    int             d_err_cnt  = 0;

    int valid_pct [8] = '{100, 60, 30, 80, 100, 50, 90, 20};
    int ack_pct   [8] = '{70, 50, 90, 0, 3, 100, 40, 60};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int idx);
        logic [NR-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic int clamp(input int raw);
        if (raw == 0) return 1;
        if (raw > 16) return 16;
        return raw;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_last   = NR - 1;
        m_left   = 0;
        m_silent = 0;
        m_active = 1'b0;
        m_wr     = 1'b0;
        m_addr   = '0;
        m_done   = -1;
        m_err    = -1;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        int nd;
        int ne;
        bit ack;
        nd = -1;
        ne = -1;
        if (m_owner < 0) begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (m_last + k) % NR;
                if (req_valid[c]) begin
                    m_owner  = c;
                    m_active = 1'b1;
                    m_wr     = req_write[c];
                    m_addr   = req_addr[c*AW +: AW];
                    m_left   = clamp(int'(req_len[c*LW +: LW]));
                    m_silent = 0;
                    break;
                end
            end
        end else if (m_active) begin
            ack = m_wr ? eflx_rvalid_data : eflx_wvalid_data;
            if (ack) begin
                m_left--;
                m_silent = 0;
                if (m_left == 0) begin
                    m_active = 1'b0;
                    nd = m_owner;
                end
            end else begin
                m_silent++;
                if (m_silent == TO) begin
                    m_active = 1'b0;
                    ne = m_owner;
                end
            end
        end else begin
            m_last  = m_owner;
            m_owner = -1;
        end
        m_done = nd;
        m_err  = ne;
        if (nd >= 0) m_done_cnt++;
        if (ne >= 0) m_err_cnt++;
    endtask

    task automatic compare_outputs();
        logic [NR-1:0] exp_wack;
        logic [NR-1:0] exp_rv;
        logic [DW-1:0] exp_ed;
        exp_wack = (m_active && m_wr && eflx_rvalid_data) ? onehot(m_owner) : '0;
        exp_rv   = (m_active && !m_wr && eflx_wvalid_data) ? onehot(m_owner) : '0;
        exp_ed   = (m_owner >= 0) ? req_wdata[m_owner*DW +: DW] : '0;
        check("grant",          64'(grant),          64'(onehot(m_owner)));
        check("target_address", 64'(TARGET_ADDRESS), 64'(m_addr));
        check("writereq",       64'(writereq),       64'(m_active && m_wr));
        check("readreq",        64'(readreq),        64'(m_active && !m_wr));
        check("req_done",       64'(req_done),       64'(onehot(m_done)));
        check("req_err",        64'(req_err),        64'(onehot(m_err)));
        check("req_wack",       64'(req_wack),       64'(exp_wack));
        check("req_rvalid",     64'(req_rvalid),     64'(exp_rv));
        check("req_rdata",      64'(req_rdata),      64'(eflx_wdata));
        check("eflx_rdata",     64'(eflx_rdata),     64'(exp_ed));
        if (|req_done) d_done_cnt++;
        if (|req_err)  d_err_cnt++;
    endtask

    initial begin
        int  seg;
        bit  rst_now;
        HRESET           = 1'b1;
        req_valid        = '0;
        req_write        = '0;
        req_addr         = '0;
        req_len          = '0;
        req_wdata        = '0;
        eflx_rvalid_data = 1'b0;
        eflx_wvalid_data = 1'b0;
        eflx_wdata       = '0;
        model_reset();
        repeat (3) @(negedge HCLK);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge HCLK);
            compare_outputs();
            seg = cyc / 500;
            rst_now = (cyc >= 1234 && cyc < 1236) || (cyc >= 2777 && cyc < 2779);
            if (rst_now && !HRESET) begin
                HRESET = 1'b1;
                #1;
                check("rst_grant",    64'(grant),    64'd0);
                check("rst_writereq", 64'(writereq), 64'd0);
                check("rst_readreq",  64'(readreq),  64'd0);
                check("rst_done_err", 64'({req_done, req_err}), 64'd0);
                check("rst_addr",     64'(TARGET_ADDRESS), 64'd0);
            end else begin
                HRESET = rst_now;
            end
            for (int i = 0; i < NR; i++) begin
                req_valid[i]            = ($urandom_range(99) < valid_pct[seg]);
                req_write[i]            = 1'($urandom_range(1));
                req_addr[i*AW +: AW]    = $urandom();
                req_len[i*LW +: LW]     = LW'($urandom_range(31));
                req_wdata[i*DW +: DW]   = $urandom();
            end
            eflx_rvalid_data = ($urandom_range(99) < ack_pct[seg]);
            eflx_wvalid_data = ($urandom_range(99) < ack_pct[seg]);
            eflx_wdata       = $urandom();
            if (HRESET) model_reset();
            else        model_step();
        end

        @(negedge HCLK);
        compare_outputs();
        check("done_count", 64'(d_done_cnt), 64'(m_done_cnt));
        check("err_count",  64'(d_err_cnt),  64'(m_err_cnt));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
